// File: rtl/ins_pkg.sv
// Shared constants and types for the RV32I writeback/commit slice.
package ins_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int REG_CNT   = 1 << REG_IDX_W;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } wb_state_t;
endpackage

// File: rtl/ins_writeback_gpr_file.sv
// 32x32 general-purpose register file: one write port, two combinational
// read ports, x0 hardwired to zero, asynchronous clear.
module gpr_file
  import ins_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  output logic [XLEN-1:0]      o_rdata1,
  output logic [XLEN-1:0]      o_rdata2
);
  logic [XLEN-1:0] r_regs [REG_CNT];

  // Entry 0 is cleared but never written, so x0 stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
endmodule

// File: rtl/ins_writeback.sv
// Writeback/commit stage: one-entry pipeline register, architectural PC,
// bypassed GPR reads and a misaligned-target trap FSM.
module ins_writeback
  import ins_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic                 reg_pc_w_op,
  input  logic [XLEN-1:0]      reg_pc_w_val,
  input  logic                 reg_w_op,
  input  logic [REG_IDX_W-1:0] reg_w_reg_idx,
  input  logic [XLEN-1:0]      reg_w_reg_val,
  output logic [XLEN-1:0]      reg_pc_val,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 commit,
  output logic                 exc,
  output logic [XLEN-1:0]      exc_pc,
  input  logic                 exc_ack
);
  wb_state_t r_state, w_state_next;

  logic                 r_p_valid;
  logic                 r_p_pc_w_op;
  logic [XLEN-1:0]      r_p_pc_w_val;
  logic                 r_p_w_op;
  logic [REG_IDX_W-1:0] r_p_idx;
  logic [XLEN-1:0]      r_p_val;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_exc_pc;

  logic            w_accept, w_misaligned, w_load;
  logic            w_byp1, w_byp2;
  logic [XLEN-1:0] w_gpr1, w_gpr2;

  assign wb_ready     = (r_state == RUN);
  assign w_accept     = wb_valid & wb_ready;
  assign w_misaligned = reg_pc_w_op & (reg_pc_w_val[1:0] != 2'b00);
  assign w_load       = w_accept & ~w_misaligned;

  always_comb begin
    w_state_next = r_state;
    if (r_state == RUN) begin
      if (w_accept && w_misaligned) w_state_next = TRAP;
    end else begin
      if (exc_ack) w_state_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // A faulting accept leaves the pipeline empty, so a commit and a trap
  // acknowledge never compete for the PC on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid    <= 1'b0;
      r_p_pc_w_op  <= 1'b0;
      r_p_pc_w_val <= '0;
      r_p_w_op     <= 1'b0;
      r_p_idx      <= '0;
      r_p_val      <= '0;
    end else begin
      r_p_valid <= w_load;
      if (w_load) begin
        r_p_pc_w_op  <= reg_pc_w_op;
        r_p_pc_w_val <= reg_pc_w_val;
        r_p_w_op     <= reg_w_op;
        r_p_idx      <= reg_w_reg_idx;
        r_p_val      <= reg_w_reg_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (r_p_valid) begin
      r_pc <= r_p_pc_w_op ? r_p_pc_w_val : r_pc + XLEN'(4);
    end else if ((r_state == TRAP) && exc_ack) begin
      r_pc <= TRAP_VEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_exc_pc <= '0;
    else if (w_accept && w_misaligned) r_exc_pc <= r_pc;
  end

  gpr_file u_gpr (
    .clk      (clk),
    .rst      (rst),
    .i_we     (r_p_valid & r_p_w_op),
    .i_waddr  (r_p_idx),
    .i_wdata  (r_p_val),
    .i_raddr1 (rs1_idx),
    .i_raddr2 (rs2_idx),
    .o_rdata1 (w_gpr1),
    .o_rdata2 (w_gpr2)
  );

  // Forward the value that will be written at the next edge.
  assign w_byp1  = r_p_valid & r_p_w_op & (r_p_idx == rs1_idx) & (rs1_idx != '0);
  assign w_byp2  = r_p_valid & r_p_w_op & (r_p_idx == rs2_idx) & (rs2_idx != '0);
  assign rs1_val = w_byp1 ? r_p_val : w_gpr1;
  assign rs2_val = w_byp2 ? r_p_val : w_gpr2;

  assign reg_pc_val = r_pc;
  assign commit     = r_p_valid;
  assign exc        = (r_state == TRAP);
  assign exc_pc     = r_exc_pc;
endmodule

// File: tb/tb_ins_writeback.sv
// Self-checking bench for ins_writeback: directed vector table, hand-written
// reset/trap sequences, and randomized traffic against a behavioural model.
module tb_ins_writeback;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int NVEC = 26;
  localparam int NRAND = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic [31:0] reg_pc_val;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        commit, exc;
  logic [31:0] exc_pc;
  logic        exc_ack;

  ins_writeback #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val),
    .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
    .reg_pc_val(reg_pc_val), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .commit(commit), .exc(exc),
    .exc_pc(exc_pc), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic pcw, input logic [31:0] pcv,
                       input logic w, input logic [4:0] idx, input logic [31:0] val,
                       input logic [4:0] r1, input logic [4:0] r2, input logic ack);
    wb_valid = v; reg_pc_w_op = pcw; reg_pc_w_val = pcv;
    reg_w_op = w; reg_w_reg_idx = idx; reg_w_reg_val = val;
    rs1_idx = r1; rs2_idx = r2; exc_ack = ack;
  endtask

  typedef struct {
    logic        v;
    logic        pcw;
    logic [31:0] pcv;
    logic        w;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [4:0]  rs;
    logic        ack;
    logic        e_commit;
    logic [31:0] e_pc;
    logic [31:0] e_rs;
    logic        e_ready;
    logic        e_exc;
    logic [31:0] e_exc_pc;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(logic v, logic pcw, logic [31:0] pcv, logic w, logic [4:0] idx,
                              logic [31:0] val, logic [4:0] rs, logic ack, logic e_commit,
                              logic [31:0] e_pc, logic [31:0] e_rs, logic e_ready,
                              logic e_exc, logic [31:0] e_exc_pc);
    vec_t t;
    t.v = v; t.pcw = pcw; t.pcv = pcv; t.w = w; t.idx = idx; t.val = val; t.rs = rs;
    t.ack = ack; t.e_commit = e_commit; t.e_pc = e_pc; t.e_rs = e_rs;
    t.e_ready = e_ready; t.e_exc = e_exc; t.e_exc_pc = e_exc_pc;
    return t;
  endfunction

  // Behavioural model state for the random phase.
  typedef struct {
    logic        pcw;
    logic [31:0] pcv;
    logic        w;
    logic [4:0]  idx;
    logic [31:0] val;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_gpr [32];
  bit          m_trap;
  logic [31:0] m_exc_pc;
  ent_t        m_pend [$];

  function automatic logic [31:0] m_read(logic [4:0] r);
    logic [31:0] res;
    res = m_gpr[r];
    foreach (m_pend[k])
      if (m_pend[k].w && m_pend[k].idx == r && r != 5'd0) res = m_pend[k].val;
    return (r == 5'd0) ? 32'd0 : res;
  endfunction

  initial begin
    //          v pcw pcv            w idx val            rs ack com pc             rs             rdy exc excpc
    tbl[0]  = mk(0,0,32'h0,          0,0, 32'h0,          5, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0);
    tbl[1]  = mk(1,0,32'h0,          1,5, 32'hDEAD_BEEF,  5, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0);
    tbl[2]  = mk(0,0,32'h0,          0,0, 32'h0,          5, 0, 1, 32'h0,         32'hDEAD_BEEF, 1, 0, 32'h0);
    tbl[3]  = mk(0,0,32'h0,          0,0, 32'h0,          5, 0, 0, 32'h4,         32'hDEAD_BEEF, 1, 0, 32'h0);
    tbl[4]  = mk(1,1,32'h40,         1,1, 32'h4,          1, 0, 0, 32'h4,         32'h0,         1, 0, 32'h0);
    tbl[5]  = mk(0,0,32'h0,          0,0, 32'h0,          1, 0, 1, 32'h4,         32'h4,         1, 0, 32'h0);
    tbl[6]  = mk(1,0,32'h0,          1,0, 32'h1234,       1, 0, 0, 32'h40,        32'h4,         1, 0, 32'h0);
    tbl[7]  = mk(0,0,32'h0,          0,0, 32'h0,          0, 0, 1, 32'h40,        32'h0,         1, 0, 32'h0);
    tbl[8]  = mk(1,1,32'h10,         0,0, 32'h0,          0, 0, 0, 32'h44,        32'h0,         1, 0, 32'h0);
    tbl[9]  = mk(0,0,32'h0,          0,0, 32'h0,          0, 0, 1, 32'h44,        32'h0,         1, 0, 32'h0);
    tbl[10] = mk(1,1,32'h42,         1,3, 32'h77,         3, 0, 0, 32'h10,        32'h0,         1, 0, 32'h0);
    tbl[11] = mk(0,0,32'h0,          0,0, 32'h0,          3, 0, 0, 32'h10,        32'h0,         0, 1, 32'h10);
    tbl[12] = mk(1,0,32'h0,          1,3, 32'h99,         3, 0, 0, 32'h10,        32'h0,         0, 1, 32'h10);
    tbl[13] = mk(0,0,32'h0,          0,0, 32'h0,          3, 1, 0, 32'h10,        32'h0,         0, 1, 32'h10);
    tbl[14] = mk(0,0,32'h0,          0,0, 32'h0,          3, 0, 0, 32'h100,       32'h0,         1, 0, 32'h0);
    tbl[15] = mk(0,0,32'h0,          0,0, 32'h0,          3, 1, 0, 32'h100,       32'h0,         1, 0, 32'h0);
    tbl[16] = mk(1,0,32'h0,          1,2, 32'h1,          2, 0, 0, 32'h100,       32'h0,         1, 0, 32'h0);
    tbl[17] = mk(1,0,32'h0,          1,2, 32'h2,          2, 0, 1, 32'h100,       32'h1,         1, 0, 32'h0);
    tbl[18] = mk(1,0,32'h0,          1,2, 32'h3,          2, 0, 1, 32'h104,       32'h2,         1, 0, 32'h0);
    tbl[19] = mk(1,0,32'h0,          1,2, 32'h4,          2, 0, 1, 32'h108,       32'h3,         1, 0, 32'h0);
    tbl[20] = mk(0,0,32'h0,          0,0, 32'h0,          2, 0, 1, 32'h10C,       32'h4,         1, 0, 32'h0);
    tbl[21] = mk(0,0,32'h0,          0,0, 32'h0,          2, 0, 0, 32'h110,       32'h4,         1, 0, 32'h0);
    tbl[22] = mk(1,1,32'hFFFF_FFFC,  0,0, 32'h0,          2, 0, 0, 32'h110,       32'h4,         1, 0, 32'h0);
    tbl[23] = mk(1,0,32'h0,          0,0, 32'h0,          2, 0, 1, 32'h110,       32'h4,         1, 0, 32'h0);
    tbl[24] = mk(0,0,32'h0,          0,0, 32'h0,          2, 0, 1, 32'hFFFF_FFFC, 32'h4,         1, 0, 32'h0);
    tbl[25] = mk(0,0,32'h0,          0,0, 32'h0,          2, 0, 0, 32'h0,         32'h4,         1, 0, 32'h0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset commit", {31'b0, commit}, 32'd0);
    chk("reset exc", {31'b0, exc}, 32'd0);
    chk("reset ready", {31'b0, wb_ready}, 32'd1);
    chk("reset pc", reg_pc_val, RESET_PC);
    chk("reset exc_pc", exc_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      drive(tbl[k].v, tbl[k].pcw, tbl[k].pcv, tbl[k].w, tbl[k].idx, tbl[k].val,
            tbl[k].rs, tbl[k].rs, tbl[k].ack);
      @(negedge clk);
      $display("[TB] vec %0d: v=%0b pcw=%0b pcv=%h w=%0b x%0d=%h rs=%0d ack=%0b -> pc=%h rs=%h commit=%0b exc=%0b",
               k, tbl[k].v, tbl[k].pcw, tbl[k].pcv, tbl[k].w, tbl[k].idx, tbl[k].val,
               tbl[k].rs, tbl[k].ack, reg_pc_val, rs1_val, commit, exc);
      chk($sformatf("vec%0d commit", k), {31'b0, commit}, {31'b0, tbl[k].e_commit});
      chk($sformatf("vec%0d pc", k), reg_pc_val, tbl[k].e_pc);
      chk($sformatf("vec%0d rs1", k), rs1_val, tbl[k].e_rs);
      chk($sformatf("vec%0d rs2", k), rs2_val, tbl[k].e_rs);
      chk($sformatf("vec%0d ready", k), {31'b0, wb_ready}, {31'b0, tbl[k].e_ready});
      chk($sformatf("vec%0d exc", k), {31'b0, exc}, {31'b0, tbl[k].e_exc});
      if (tbl[k].e_exc) chk($sformatf("vec%0d exc_pc", k), exc_pc, tbl[k].e_exc_pc);
      @(posedge clk); #1;
    end

    // Asynchronous reset with an entry pending: no commit, everything cleared.
    drive(1, 0, 0, 1, 2, 32'hAAAA, 2, 5, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 2, 5, 0);
    chk("midrst pre bypass", rs1_val, 32'hAAAA);
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset with pending entry: commit=%0b pc=%h", commit, reg_pc_val);
    chk("midrst commit", {31'b0, commit}, 32'd0);
    chk("midrst pc", reg_pc_val, RESET_PC);
    for (int r = 0; r < 32; r++) begin
      rs1_idx = 5'(r);
      rs2_idx = 5'(31 - r);
      #0.1;
      chk($sformatf("midrst x%0d", r), rs1_val, 32'd0);
      chk($sformatf("midrst x%0d p2", 31 - r), rs2_val, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst commit", {31'b0, commit}, 32'd0);
    chk("postrst pc", reg_pc_val, RESET_PC);
    @(posedge clk); #1;

    // Reset also discards a pending trap.
    drive(1, 1, 32'h0000_0003, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("trap pending exc", {31'b0, exc}, 32'd1);
    rst = 1'b1;
    #1;
    $display("[TB] async reset during trap: exc=%0b ready=%0b", exc, wb_ready);
    chk("trap reset exc", {31'b0, exc}, 32'd0);
    chk("trap reset ready", {31'b0, wb_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model.
    m_pc = RESET_PC;
    m_trap = 1'b0;
    m_exc_pc = 32'd0;
    m_pend.delete();
    for (int r = 0; r < 32; r++) m_gpr[r] = 32'd0;
    for (int c = 0; c < NRAND; c++) begin
      logic        v, pcw, w, ack, was_trap;
      logic [31:0] pcv, val, pc_before;
      logic [4:0]  idx, r1, r2;
      ent_t        e;
      v   = ($urandom_range(0, 9) < 7);
      pcw = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       pcv = 32'hFFFF_FFFC;
        1, 2:    pcv = $urandom() | 32'h1;
        default: pcv = $urandom() & 32'hFFFF_FFFC;
      endcase
      w   = ($urandom_range(0, 4) < 3);
      idx = 5'($urandom_range(0, 31));
      val = $urandom();
      r1  = ($urandom_range(0, 1) == 0) ? idx : 5'($urandom_range(0, 31));
      r2  = 5'($urandom_range(0, 31));
      ack = ($urandom_range(0, 9) < 4);
      drive(v, pcw, pcv, w, idx, val, r1, r2, ack);
      @(negedge clk);
      chk($sformatf("rnd%0d ready", c), {31'b0, wb_ready}, {31'b0, !m_trap});
      chk($sformatf("rnd%0d exc", c), {31'b0, exc}, {31'b0, m_trap});
      chk($sformatf("rnd%0d commit", c), {31'b0, commit}, {31'b0, m_pend.size() != 0});
      chk($sformatf("rnd%0d pc", c), reg_pc_val, m_pc);
      chk($sformatf("rnd%0d rs1 x%0d", c, r1), rs1_val, m_read(r1));
      chk($sformatf("rnd%0d rs2 x%0d", c, r2), rs2_val, m_read(r2));
      if (m_trap) chk($sformatf("rnd%0d exc_pc", c), exc_pc, m_exc_pc);
      if (v && !m_trap)
        $display("[TB] rnd %0d: accept pcw=%0b pcv=%h w=%0b x%0d=%h pc=%h",
                 c, pcw, pcv, w, idx, val, m_pc);

      was_trap  = m_trap;
      pc_before = m_pc;
      if (m_pend.size() != 0) begin
        e = m_pend.pop_front();
        m_pc = e.pcw ? e.pcv : m_pc + 32'd4;
        if (e.w && e.idx != 5'd0) m_gpr[e.idx] = e.val;
      end
      if (was_trap && ack) begin
        m_pc = TRAP_VEC;
        m_trap = 1'b0;
      end
      if (!was_trap && v) begin
        if (pcw && pcv[1:0] != 2'b00) begin
          m_trap = 1'b1;
          m_exc_pc = pc_before;
        end else begin
          e.pcw = pcw; e.pcv = pcv; e.w = w; e.idx = idx; e.val = val;
          m_pend.push_back(e);
        end
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
